// File: rtl/sm_dip_debounce_pkg.sv
// Shared constants and counter-decision helper for the DIP switch debouncer.
// Board defaults live here; benches override them through module parameters.
package sm_dip_debounce_pkg;

    localparam int DIP_WIDTH  = 8;
    localparam int DIP_STABLE = 50000;
    localparam int DIP_CNT_W  = 16;

    typedef enum logic [1:0] {
        CNT_CLEAR  = 2'd0,
        CNT_INC    = 2'd1,
        CNT_COMMIT = 2'd2,
        CNT_SAT    = 2'd3
    } cnt_act_e;

    // One bit's counter decision for the current edge.
    function automatic cnt_act_e cntAction(input logic differ, input logic atLast,
                                           input logic hold);
        cnt_act_e act;
        act = CNT_CLEAR;
        if (differ) begin
            if (!atLast)   act = CNT_INC;
            else if (hold) act = CNT_SAT;
            else           act = CNT_COMMIT;
        end
        return act;
    endfunction

endpackage

// File: rtl/sm_dip_debounce_if.sv
// Switch-side bundle: raw levels and hold in, debounced value and change strobe out.
interface sm_dip_debounce_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] dip_raw;
    logic             hold;
    logic [WIDTH-1:0] dipValue;
    logic             changed;
    logic [WIDTH-1:0] changed_mask;

    modport master (
        output dip_raw, hold,
        input  dipValue, changed, changed_mask
    );

    modport slave (
        input  dip_raw, hold,
        output dipValue, changed, changed_mask
    );
endinterface

// File: rtl/sm_dip_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter and commit register.
// commit is combinational and is high on the edge that loads out.
module sm_debounce_bit
    import sm_dip_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DIP_STABLE,
    parameter int CNT_W         = DIP_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic hold,
    input  logic rst_val,
    output logic out,
    output logic commit
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1, s2;
    logic [CNT_W-1:0] cnt;
    cnt_act_e         act;

    always_comb begin
        act    = cntAction(s2 != out, cnt == LAST, hold);
        commit = (act == CNT_COMMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1  <= rst_val;
            s2  <= rst_val;
            out <= rst_val;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            unique case (act)
                CNT_CLEAR:  cnt <= '0;
                CNT_INC:    cnt <= cnt + 1'b1;
                CNT_COMMIT: begin
                    cnt <= '0;
                    out <= s2;
                end
                CNT_SAT:    cnt <= cnt;
                default:    cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/sm_dip_debounce.sv
// DIP switch conditioner feeding sm_cpu.dipValue: per-bit debounce lanes plus a
// registered change strobe/mask aligned with the new dipValue.
module sm_dip_debounce
    import sm_dip_debounce_pkg::*;
#(
    parameter int               WIDTH         = DIP_WIDTH,
    parameter int               STABLE_CYCLES = DIP_STABLE,
    parameter int               CNT_W         = DIP_CNT_W,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    sm_dip_debounce_if.slave   dip
);

    if (STABLE_CYCLES < 1) begin : g_badStable
        $error("sm_dip_debounce: STABLE_CYCLES must be >= 1");
    end
    if (longint'(STABLE_CYCLES) > (longint'(1) << CNT_W)) begin : g_badCntW
        $error("sm_dip_debounce: STABLE_CYCLES exceeds 2**CNT_W");
    end

    logic [WIDTH-1:0] commit;
    logic [WIDTH-1:0] value;
    logic             changedQ;
    logic [WIDTH-1:0] maskQ;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sm_debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W)
        ) u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw     (dip.dip_raw[i]),
            .hold    (dip.hold),
            .rst_val (RESET_VALUE[i]),
            .out     (value[i]),
            .commit  (commit[i])
        );
    end

    // Registered from the same edge that loads the lanes, so the strobe and
    // the new value become visible together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            changedQ <= 1'b0;
            maskQ    <= '0;
        end else begin
            changedQ <= |commit;
            maskQ    <= commit;
        end
    end

    assign dip.dipValue     = value;
    assign dip.changed      = changedQ;
    assign dip.changed_mask = maskQ;

endmodule
